// File: rtl/muldiv_sequencer_pkg.sv
// Shared codes for the iterative multiply/divide unit.
// Holds the operation and state enums and the decoder's FUNC-to-op mapping.
package muldiv_sequencer_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  // The decoder only raises start_i for these functs, so the default is never issued.
  function automatic md_op_t func_to_md_op(input logic [5:0] func);
    md_op_t op;
    case (func)
      FUNC_MULT:  op = MD_MULT;
      FUNC_MULTU: op = MD_MULTU;
      FUNC_DIV:   op = MD_DIV;
      FUNC_DIVU:  op = MD_DIVU;
      FUNC_MTHI:  op = MD_MTHI;
      FUNC_MTLO:  op = MD_MTLO;
      default:    op = MD_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side request/result bundle of the multiply/divide unit.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  import muldiv_sequencer_pkg::*;

  logic             start_i;
  md_op_t           op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             mf_read_i;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] mfhi_o;
  logic [WIDTH-1:0] mflo_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, mf_read_i,
    input  busy_o, stall_o, done_o, mfhi_o, mflo_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mf_read_i,
    output busy_o, stall_o, done_o, mfhi_o, mflo_o
  );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// One radix-2 iteration: right-shifting shift-add for multiply,
// left-shifting restoring trial-subtract for divide.
module muldiv_sequencer_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic             ge_s;
  logic [WIDTH-1:0] diff_s;

  // Both datapaths are evaluated; the op flag picks which one advances the work registers.
  always_comb begin
    sum_s     = lo_i[0] ? ({1'b0, hi_i} + {1'b0, m_i}) : {1'b0, hi_i};
    shifted_s = {hi_i, lo_i[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, m_i});
    diff_s    = shifted_s[WIDTH-1:0] - m_i;
    hi_o      = '0;
    lo_o      = '0;
    if (is_div_i) begin
      if (ge_s) begin
        hi_o = diff_s;
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted_s[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum_s[WIDTH:1];
      lo_o = {sum_s[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO. Operands are reduced to
// magnitudes on accept, iterated WIDTH times, then sign-corrected into HI/LO.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset_ni,
  muldiv_sequencer_if.slave md
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   wh_q, wh_d, wl_q, wl_d, m_q, m_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic               done_q, done_d;

  logic               op_signed_s, op_div_s;
  logic [WIDTH-1:0]   rs_mag_s, rt_mag_s, step_hi_s, step_lo_s;
  logic [2*WIDTH-1:0] prod_s;

  muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .hi_i     (wh_q),
    .lo_i     (wl_q),
    .m_i      (m_q),
    .hi_o     (step_hi_s),
    .lo_o     (step_lo_s)
  );

  // Operand magnitudes; 0x80000000 maps to itself, which the unsigned datapath handles.
  always_comb begin
    op_signed_s = (md.op_i == MD_MULT) || (md.op_i == MD_DIV);
    op_div_s    = (md.op_i == MD_DIV)  || (md.op_i == MD_DIVU);
    rs_mag_s    = (op_signed_s && md.rs_i[WIDTH-1]) ? (~md.rs_i + WIDTH'(1)) : md.rs_i;
    rt_mag_s    = (op_signed_s && md.rt_i[WIDTH-1]) ? (~md.rt_i + WIDTH'(1)) : md.rt_i;
    prod_s      = neg_q ? (~{wh_q, wl_q} + (2*WIDTH)'(1)) : {wh_q, wl_q};
  end

  // Next-state, work-register and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wh_d      = wh_q;
    wl_d      = wl_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    done_d    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md.start_i) begin
          case (md.op_i)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_d  = op_div_s;
              neg_d     = op_signed_s && (md.rs_i[WIDTH-1] ^ md.rt_i[WIDTH-1]);
              rem_neg_d = op_signed_s && md.rs_i[WIDTH-1];
              wh_d      = '0;
              wl_d      = rs_mag_s;
              m_d       = rt_mag_s;
              cnt_d     = CNT_W'(WIDTH - 1);
              // Zeroed work registers make FIX write HI=LO=0 for a zero divisor.
              if (op_div_s && (md.rt_i == '0)) begin
                state_d   = MD_FIX;
                wl_d      = '0;
                neg_d     = 1'b0;
                rem_neg_d = 1'b0;
              end else begin
                state_d = MD_RUN;
              end
            end
            MD_MTHI: hi_d = md.rs_i;
            MD_MTLO: lo_d = md.rs_i;
            default: state_d = MD_IDLE;
          endcase
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_RUN: begin
        wh_d = step_hi_s;
        wl_d = step_lo_s;
        if (cnt_q == '0) begin
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MD_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q     ? (~wl_q + WIDTH'(1)) : wl_q;
          hi_d = rem_neg_q ? (~wh_q + WIDTH'(1)) : wh_q;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers; reset also clears the architectural HI/LO.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wh_q      <= '0;
      wl_q      <= '0;
      m_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wh_q      <= wh_d;
      wl_q      <= wl_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
    end
  end

  assign md.busy_o  = (state_q != MD_IDLE);
  assign md.stall_o = md.busy_o & (md.start_i | md.mf_read_i);
  assign md.done_o  = done_q;
  assign md.mfhi_o  = hi_q;
  assign md.mflo_o  = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: an arithmetic reference model is checked
// against the DUT every cycle, plus literal checks of the documented results.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_ni;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) md ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .md       (md)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // {HI, LO} an op must leave behind, from plain 64-bit arithmetic.
  function automatic logic [63:0] model_result(md_op_t op, logic [31:0] a, logic [31:0] b);
    longint     sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (op)
      MD_MULT:  r = sa * sb;
      MD_MULTU: r = {32'd0, a} * {32'd0, b};
      MD_DIV:   if (b != 32'd0) begin r[31:0] = 32'(sa / sb); r[63:32] = 32'(sa % sb); end
      MD_DIVU:  if (b != 32'd0) begin r[31:0] = a / b; r[63:32] = a % b; end
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

  int          m_cnt;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;

  // Reference model: busy for 33 cycles (1 on divide by zero), result lands as busy ends.
  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_cnt <= 0; m_hi <= 32'd0; m_lo <= 32'd0; p_hi <= 32'd0; p_lo <= 32'd0; m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (md.start_i) begin
        if (md.op_i == MD_MTHI) m_hi <= md.rs_i;
        else if (md.op_i == MD_MTLO) m_lo <= md.rs_i;
        else if (md.op_i inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
          {p_hi, p_lo} <= model_result(md.op_i, md.rs_i, md.rt_i);
          m_cnt <= ((md.op_i inside {MD_DIV, MD_DIVU}) && md.rt_i == 32'd0) ? 1 : 33;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_ni === 1'b1) begin
      check("busy",  {63'd0, md.busy_o},  {63'd0, m_cnt != 0});
      check("stall", {63'd0, md.stall_o}, {63'd0, (m_cnt != 0) && (md.start_i || md.mf_read_i)});
      check("done",  {63'd0, md.done_o},  {63'd0, m_done});
      check("mfhi",  {32'd0, md.mfhi_o},  {32'd0, m_hi});
      check("mflo",  {32'd0, md.mflo_o},  {32'd0, m_lo});
    end
  end

  task automatic wait_done(input string name, input int exp_busy);
    int  busy_cycles = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (md.busy_o) busy_cycles++;
      if (md.done_o) begin seen = 1'b1; break; end
    end
    check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
  endtask

  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    md.start_i = 1'b1; md.op_i = op; md.rs_i = a; md.rt_i = b;
    @(posedge clk); #1;
    md.start_i = 1'b0;
  endtask

  task automatic run_op(input string name, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    wait_done(name, exp_busy);
    check({name, "_hi"}, {32'd0, md.mfhi_o}, {32'd0, exp_hi});
    check({name, "_lo"}, {32'd0, md.mflo_o}, {32'd0, exp_lo});
  endtask

  initial begin
    md.start_i = 1'b0; md.op_i = MD_MULT; md.rs_i = 32'd0; md.rt_i = 32'd0; md.mf_read_i = 1'b0;
    reset_ni = 1'b0;

    check("model_mult",  model_result(MD_MULT, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    check("model_div",   model_result(MD_DIV, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    check("model_divov", model_result(MD_DIV, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    repeat (3) @(posedge clk); #1;
    check("rst_busy", {63'd0, md.busy_o}, 64'd0);
    check("rst_done", {63'd0, md.done_o}, 64'd0);
    check("rst_hi",   {32'd0, md.mfhi_o}, 64'd0);
    check("rst_lo",   {32'd0, md.mflo_o}, 64'd0);
    reset_ni = 1'b1;

    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'd7,        33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    run_op("div_zero",  MD_DIV,   32'd5,        32'd0,        1,  32'h00000000, 32'h00000000);

    // MTHI/MTLO then MF reads while idle: no stall.
    issue(MD_MTHI, 32'h12345678, 32'd0);
    issue(MD_MTLO, 32'hCAFEF00D, 32'd0);
    md.mf_read_i = 1'b1;
    @(negedge clk);
    check("mf_idle_stall", {63'd0, md.stall_o}, 64'd0);
    check("mthi_val", {32'd0, md.mfhi_o}, 64'h12345678);
    check("mtlo_val", {32'd0, md.mflo_o}, 64'hCAFEF00D);
    @(posedge clk); #1;
    md.mf_read_i = 1'b0;

    // DIVU with an MF read at cycle 5 and a new start held while busy.
    issue(MD_DIVU, 32'd1000, 32'd33);
    repeat (4) @(posedge clk); #1;
    md.mf_read_i = 1'b1;
    md.start_i = 1'b1; md.op_i = MD_MULTU; md.rs_i = 32'd3; md.rt_i = 32'd5;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!md.busy_o) break;
      check("held_stall", {63'd0, md.stall_o}, 64'd1);
    end
    check("divu_done", {63'd0, md.done_o}, 64'd1);
    check("idle_stall", {63'd0, md.stall_o}, 64'd0);
    check("divu_lo", {32'd0, md.mflo_o}, 64'd30);
    check("divu_hi", {32'd0, md.mfhi_o}, 64'd10);
    @(posedge clk); #1;
    md.start_i = 1'b0; md.mf_read_i = 1'b0;
    wait_done("queued_multu", 33);
    check("queued_hi", {32'd0, md.mfhi_o}, 64'd0);
    check("queued_lo", {32'd0, md.mflo_o}, 64'd15);

    // Reset in the middle of a MULT aborts it and clears HI/LO.
    issue(MD_MULT, 32'h00001234, 32'h00005678);
    repeat (9) @(posedge clk); #1;
    reset_ni = 1'b0;
    @(negedge clk);
    check("midrst_busy", {63'd0, md.busy_o}, 64'd0);
    check("midrst_done", {63'd0, md.done_o}, 64'd0);
    check("midrst_hi",   {32'd0, md.mfhi_o}, 64'd0);
    check("midrst_lo",   {32'd0, md.mflo_o}, 64'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;

    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
